// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder (G1=1111, G0=1101) with framing and a registered output slot.
// Define TAIL_FLUSH_EN to append three zero tail pairs per frame; otherwise the state is cleared at each frame end.
module conv_encoder #(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  logic [2:0]    s, s_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    pair_nx;
  logic          valid_nx, last_nx;
  logic          slot_free;

  function automatic logic [1:0] encode(input logic d, input logic [2:0] st);
    return {d ^ st[0] ^ st[1] ^ st[2], d ^ st[0] ^ st[2]};
  endfunction

`ifdef TAIL_FLUSH_EN
  typedef enum logic {DATA, TAIL} state_t;
  state_t     state, state_nx;
  logic [1:0] tcnt, tcnt_nx;

  always_comb begin
    slot_free = !out_valid || out_ready;
    s_nx      = s;
    cnt_nx    = cnt;
    pair_nx   = out_pair;
    valid_nx  = out_valid;
    last_nx   = out_last;
    state_nx  = state;
    tcnt_nx   = tcnt;
    in_ready  = slot_free && (state == DATA);
    busy      = (state != DATA) || (cnt != '0);
    if (slot_free) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
    if (state == DATA) begin
      if (in_valid && in_ready) begin
        pair_nx  = encode(in_bit, s);
        valid_nx = 1'b1;
        s_nx     = {s[1:0], in_bit};
        if (cnt == CNT_LAST) begin
          state_nx = TAIL;
          tcnt_nx  = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    end else if (slot_free) begin
      // Zero tail bits drain the shift register back to 000 over three pairs.
      pair_nx  = encode(1'b0, s);
      valid_nx = 1'b1;
      s_nx     = {s[1:0], 1'b0};
      if (tcnt == 2'd2) begin
        last_nx  = 1'b1;
        state_nx = DATA;
        cnt_nx   = '0;
        tcnt_nx  = '0;
      end else begin
        tcnt_nx = tcnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DATA;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
    end
  end
`else
  always_comb begin
    slot_free = !out_valid || out_ready;
    s_nx      = s;
    cnt_nx    = cnt;
    pair_nx   = out_pair;
    valid_nx  = out_valid;
    last_nx   = out_last;
    in_ready  = slot_free;
    busy      = (cnt != '0);
    if (slot_free) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
    if (in_valid && in_ready) begin
      pair_nx  = encode(in_bit, s);
      valid_nx = 1'b1;
      if (cnt == CNT_LAST) begin
        // Without a tail the next frame must still start from state 000.
        last_nx = 1'b1;
        s_nx    = '0;
        cnt_nx  = '0;
      end else begin
        s_nx   = {s[1:0], in_bit};
        cnt_nx = cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      cnt       <= '0;
      out_pair  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      s         <= s_nx;
      cnt       <= cnt_nx;
      out_pair  <= pair_nx;
      out_valid <= valid_nx;
      out_last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames plus randomized handshakes against a
// sequence-level convolution model. Honours TAIL_FLUSH_EN the same way as the design.
module tb_conv_encoder;

  localparam int FL = 4;
`ifdef TAIL_FLUSH_EN
  localparam int TAILN = 3;
`else
  localparam int TAILN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_bit;
  logic       out_valid, out_ready, out_last, busy;
  logic [1:0] out_pair;

  int checks = 0;
  int failures = 0;

  logic [2:0] expq[$];
  logic [1:0] obs[$];
  logic [1:0] imp[$];
  logic [1:0] ones[$];
  logic       x[FL+3];
  int pos = 0;
  int tails = 0;
  int since_last = 0;
  int lasts_seen = 0;
  int frames_acc = 0;

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pair (out_pair),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Output pair at frame position p: taps over the current and three previous frame bits.
  function automatic logic [1:0] pair_at(input int p);
    logic h[4];
    for (int k = 0; k < 4; k++) begin
      if (p - k >= 0) h[k] = x[p-k];
      else h[k] = 1'b0;
    end
    return {h[0] ^ h[1] ^ h[2] ^ h[3], h[0] ^ h[1] ^ h[3]};
  endfunction

  task automatic model_accept(input logic b);
    x[pos] = b;
    expq.push_back({(TAILN == 0) && (pos == FL - 1), pair_at(pos)});
    if (pos == FL - 1) begin
      for (int k = 0; k < TAILN; k++) begin
        x[FL+k] = 1'b0;
        expq.push_back({k == TAILN - 1, pair_at(FL + k)});
      end
      tails = TAILN;
      pos = 0;
      frames_acc++;
    end else begin
      pos++;
    end
  endtask

  task automatic step(input logic v, input logic b, input logic r, output logic acc);
    logic       slot;
    logic [2:0] e;
    @(negedge clk);
    in_valid = v;
    in_bit = b;
    out_ready = r;
    #1;
    slot = !out_valid || out_ready;
    check("in_ready", 8'(in_ready), 8'(slot && (tails == 0)));
    check("busy", 8'(busy), 8'((pos != 0) || (tails != 0)));
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_pair", 8'(out_pair), 8'hff);
      end else begin
        e = expq.pop_front();
        check("pair", 8'(out_pair), 8'(e[1:0]));
        check("last", 8'(out_last), 8'(e[2]));
        obs.push_back(out_pair);
        since_last++;
        if (out_last) begin
          lasts_seen++;
          check("frame_pairs", 8'(since_last), 8'(FL + TAILN));
          since_last = 0;
        end
      end
    end
    acc = v && in_ready;
    if (slot && tails > 0) tails--;
    else if (acc) model_accept(b);
  endtask

  task automatic feed_bits(input logic [15:0] bits, input int n);
    logic acc;
    int g;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      g = 0;
      while (!acc && g < 50) begin
        step(1'b1, bits[i], 1'b1, acc);
        g++;
      end
      if (!acc) check("feed_timeout", 8'(g), 8'(0));
    end
  endtask

  task automatic drain();
    logic acc;
    int g = 0;
    while ((expq.size() != 0 || tails != 0) && g < 200) begin
      step(1'b0, 1'b0, 1'b1, acc);
      g++;
    end
    step(1'b0, 1'b0, 1'b1, acc);
    check("drain_left", 8'(expq.size()), 8'(0));
    check("drain_valid", 8'(out_valid), 8'(0));
  endtask

  task automatic cmp_log(input string tag, input logic [1:0] want[$]);
    check({tag, "_count"}, 8'(obs.size()), 8'(want.size()));
    for (int i = 0; i < want.size() && i < obs.size(); i++)
      check({tag, "_pair"}, 8'(obs[i]), 8'(want[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int frames0, lasts0, cyc;
`ifdef TAIL_FLUSH_EN
    imp  = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    ones = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
`else
    imp  = '{2'b11, 2'b11, 2'b10, 2'b11};
    ones = '{2'b11, 2'b00, 2'b10, 2'b01};
`endif
    rst = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", 8'(out_valid), 8'(0));
    check("rst_pair", 8'(out_pair), 8'(0));
    check("rst_last", 8'(out_last), 8'(0));
    check("rst_busy", 8'(busy), 8'(0));
    check("rst_ready", 8'(in_ready), 8'(1));

    obs.delete(); feed_bits(16'h0001, 4); drain(); cmp_log("impulse", imp);
    obs.delete(); feed_bits(16'h000f, 4); drain(); cmp_log("ones", ones);
    obs.delete(); feed_bits(16'h0001, 4); drain(); cmp_log("after_ones", imp);

    // Backpressure on the first pair of a frame.
    obs.delete();
    step(1'b1, 1'b1, 1'b1, acc);
    check("bp_first_acc", 8'(acc), 8'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, acc);
      check("bp_pair", 8'(out_pair), 8'(2'b11));
      check("bp_ready", 8'(in_ready), 8'(0));
      check("bp_valid", 8'(out_valid), 8'(1));
    end
    feed_bits(16'h0000, 3); drain(); cmp_log("bp", imp);

    // Reset in the middle of a frame (in the tail when flushing).
    feed_bits(16'h000f, (TAILN != 0) ? 4 : 2);
    step(1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 8'(out_valid), 8'(0));
    check("mid_rst_busy", 8'(busy), 8'(0));
    check("mid_rst_last", 8'(out_last), 8'(0));
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    pos = 0;
    tails = 0;
    since_last = 0;
    obs.delete(); feed_bits(16'h0001, 4); drain(); cmp_log("post_rst", imp);

    // Random valid/ready gaps over many frames.
    frames0 = frames_acc;
    lasts0 = lasts_seen;
    cyc = 0;
    while (frames_acc - frames0 < 50 && cyc < 20000) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, acc);
      cyc++;
    end
    check("rand_frames", 8'(frames_acc - frames0 >= 50), 8'(1));
    drain();
    check("rand_lasts", 8'(lasts_seen - lasts0), 8'(frames_acc - frames0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-4 convolutional encoder producing the coded bit pairs consumed by the Viterbi decoder's branch-metric units. It is the transmit-side counterpart of the 8-state decoder trellis. It accepts one data bit per handshake and emits one 2-bit code pair per handshake. It frames data into fixed-length blocks and, when configured, appends zero tail bits so that every frame terminates in state 0.

## Interface
Parameters:
- FRAME_LEN, 16, data bits per frame; legal range ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, rising edge.
  - rst  in  1  asynchronous, active-low reset.
- Input handshake:
  - in_valid  in  1  in_bit is valid.
  - in_ready  out  1  encoder accepts in_bit this cycle.
  - in_bit  in  1  data bit.
- Output handshake:
  - out_valid  out  1  out_pair is valid.
  - out_ready  in  1  downstream accepts out_pair.
  - out_pair  out  2  code pair; [1]=G1 output, [0]=G0 output.
  - out_last  out  1  qualifies out_pair as the final pair of a frame.
- Status:
  - busy  out  1  high when state is not DATA or cnt is not 0, i.e. a frame is in progress.

## Operation
- Shift state s[2:0], with s[0] the newest bit; reset value 000.
- For encoder input d:
  - G1 = d^s[0]^s[1]^s[2] (generator 1111).
  - G0 = d^s[0]^s[2] (generator 1101).
  - Next state = {s[1],s[0],d}.
- Output register: out_pair, out_valid and out_last are registered.
  - The slot is free when !out_valid || out_ready.
- FSM states: DATA and TAIL. Counters: cnt (0..FRAME_LEN-1) and tcnt (0..2).
- DATA:
  - in_ready = slot free.
  - On in_valid && in_ready: encode in_bit, load the output register, cnt++.
  - On the bit with cnt==FRAME_LEN-1, go to TAIL with tcnt=0.
- TAIL:
  - in_ready = 0.
  - Each cycle the slot is free, encode d=0 and load the output register, tcnt++.
  - On tcnt==2: set out_last, go to DATA, cnt=0. The shift state is 000 by construction.
- When out_valid && !out_ready: out_pair and out_last hold stable, and no state, counter or shift update occurs.
- FRAME_LEN=1 is legal: after one data bit the FSM enters TAIL.
- Reset mid-frame aborts the frame, with no out_last. The next accepted bit starts a new frame from state 000.

## Timing
- Reset values:
  - in_ready=1 once rst is released (the slot is empty).
  - out_valid=0, out_pair=00, out_last=0, busy=0.
  - FSM in DATA, cnt=0, tcnt=0, s=000.
- Latency: out_valid rises on the clock edge that accepts the bit, so the pair is visible 1 cycle after acceptance.
- Throughput: one pair per cycle with out_ready held high. This includes simultaneous drain and load of the output register in the same cycle.
- Frame duration: a frame occupies FRAME_LEN+3 output pairs and takes at least FRAME_LEN+3 cycles. in_ready is low for the 3 tail cycles.
- in_ready depends combinationally on out_ready and the FSM state only, never on in_valid.

## Configuration
- TAIL_FLUSH_EN defined:
  - TAIL state is present and 3 zero tail pairs are appended per frame.
  - out_last marks the third tail pair.
- TAIL_FLUSH_EN undefined:
  - No TAIL state; in_ready is never forced low.
  - out_last marks the pair of the last data bit (cnt==FRAME_LEN-1).
  - At that acceptance, s is loaded with 000 instead of the shifted value, so every frame starts from state 0.
  - A frame is FRAME_LEN pairs.

## Test plan
- Impulse response, FRAME_LEN=4, flush on, out_ready=1, input 1,0,0,0 → pairs 11,11,10,11,00,00,00; out_last only on the 7th pair; in_ready low for 3 cycles.
- All ones, FRAME_LEN=4, flush on, input 1,1,1,1 → pairs 11,00,10,01,10,01,11; second frame input 1,0,0,0 → 11,11,10,11,00,00,00, which confirms the state returned to 000.
- Backpressure: hold out_ready=0 for 3 cycles while the first pair is pending → out_pair stays 11, in_ready=0, and after release the full sequence arrives with no loss or duplication.
- Random in_valid/out_ready gaps over 50 frames → output matches the reference model bit-exactly, with exactly one out_last per FRAME_LEN+3 pairs.
- Reset mid-TAIL (rst=0 for 1 cycle) → out_valid=0 and busy=0 immediately; input 1,0,0,0 afterwards → 11,11,10,11,....
- TAIL_FLUSH_EN undefined, FRAME_LEN=4, input 1,1,1,1,1 → 11,00,10,01 with out_last on the 4th pair, then 11 for the 5th bit, which confirms the state reset to 000.
